// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and defaults for the serial pattern detector.
//   state_e       - detector FSM states (FILL, ARMED, HIT)
//   DEF_PATTERN_C - pattern loaded at reset ("101"), truncated/zero-extended
//                   by the user to MAX_LEN bits
//   DEF_LEN_C     - pattern length loaded at reset
//   len_w()       - width needed to hold a length value 0..max_len
package seq_det_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,  // window not yet full
    ARMED = 2'd1,  // window full, no match on the last bit
    HIT   = 2'd2   // match seen on the previous valid edge
  } state_e;

  localparam logic [31:0] DEF_PATTERN_C = 32'b101;
  localparam int          DEF_LEN_C     = 3;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating up-counter with synchronous clear.
//   clk, reset - clock, asynchronous active-low reset
//   inc        - add one this edge (ignored once the counter is all ones)
//   clr        - synchronous clear; wins over a coincident inc
//   count      - current count
module seq_det_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-pattern detector.
// A sliding window of the last MAX_LEN valid bits is compared against a
// loadable pattern of 1..MAX_LEN bits. y is a one-cycle Moore pulse per
// match; match_count is a saturating count of matches.
//
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   x, in_valid  - serial bit and its qualifier
//   cfg_load     - latch cfg_pattern / cfg_len / cfg_overlap this edge
//   cfg_pattern  - pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      - pattern length (legal 1..MAX_LEN)
//   cfg_overlap  - 1: overlapping matches, 0: window restarts after a match
//   clr_count    - synchronous clear of match_count
//   y            - match flag (state == HIT)
//   match_count  - saturating number of matches
//   cfg_err      - one-cycle pulse when an illegal cfg_len is rejected
//   state_dbg    - current FSM state, for observation only
//
// Handshake: in_valid is a pure qualifier with no back-pressure; x is
// consumed on every rising edge where in_valid is high, except when a
// legal cfg_load is taken at the same edge, in which case the bit is dropped.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int                 DEF_LEN     = DEF_LEN_C,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic [1:0]         state_dbg
);

  state_e             state, state_n;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic               cfg_ok;
  logic               take_bit;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] mask;
  logic               full_next;
  logic               match;

  assign cfg_ok    = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // A legal config load takes priority and drops a coincident bit.
  assign take_bit  = in_valid && !cfg_ok;
  assign hist_next = {hist[MAX_LEN-2:0], x};
  assign fill_next = (fill < len) ? fill + 1'b1 : fill;
  assign full_next = (fill_next >= len);

  // Only the low len bits of the window take part in the compare, so
  // pattern bits above len are don't-cares.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign match = take_bit && full_next && (((hist_next ^ pattern) & mask) == '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // The window fill level decides FILL vs ARMED, so a valid bit seen in
  // HIT is handled exactly like one seen in ARMED; in non-overlap mode
  // the window was cleared by the match and therefore lands in FILL.
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state;
    if (cfg_ok) begin
      state_n = FILL;
    end else if (take_bit) begin
      if (match) begin
        state_n = HIT;
      end else if (full_next) begin
        state_n = ARMED;
      end else begin
        state_n = FILL;
      end
    end else if (state == HIT) begin
      state_n = overlap ? ARMED : FILL;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    y         = (state == HIT);
    state_dbg = state;
  end

  // ---------------------------------------------------------------------
  // Window, fill level and configuration
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end else if (take_bit) begin
        if (match && !overlap) begin
          // The completing bit is not reused for the next match.
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= hist_next;
          fill <= fill_next;
        end
      end
    end
  end

  // Every match is an entry into HIT, including HIT -> HIT.
  seq_det_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (clr_count),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed test of seq_detector_param (MAX_LEN=8,
// CNT_W=4) with hand-computed expected values.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 4;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;

  logic               clk;
  logic               reset;
  logic               x;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_count   (clr_count),
    .y           (y),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Drivers: inputs are applied 1ns after a rising edge, consumed at the
  // next rising edge, and outputs are observed 1ns after that edge.
  // One-shot controls (cfg_load, clr_count) are dropped after each cycle.
  // ---------------------------------------------------------------------
  task automatic cycle(input logic v, input logic b);
    in_valid = v;
    x        = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    x         = 1'b0;
    cfg_load  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ov);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    cycle(1'b0, 1'b0);
  endtask

  task automatic clear_count();
    clr_count = 1'b1;
    cycle(1'b0, 1'b0);
  endtask

  // Sends bits[n-1] first; yv collects y after each bit, first bit in MSB.
  task automatic send_stream(input logic [15:0] bits, input int n, output logic [15:0] yv);
    yv = '0;
    for (int i = n - 1; i >= 0; i--) begin
      cycle(1'b1, bits[i]);
      yv = {yv[14:0], y};
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : main
    logic [15:0] yv;
    logic [15:0] trace;
    logic [2:0]  bits3;

    reset       = 1'b0;
    x           = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    clr_count   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset defaults
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(S_FILL));

    // Default "101": pulse after the third bit only
    send_stream(16'b101, 3, yv);
    chk("def_101_y", 32'(yv[2:0]), 32'b001);
    chk("def_101_count", 32'(match_count), 32'd1);
    cycle(1'b0, 1'b0);
    chk("def_101_y_drop", 32'(y), 32'd0);
    chk("def_101_armed", 32'(state_dbg), 32'(S_ARMED));

    // Overlapping "10101": pulses after bits 3 and 5
    load_cfg(8'b101, 4'd3, 1'b1);
    clear_count();
    send_stream(16'b10101, 5, yv);
    chk("ovl_10101_y", 32'(yv[4:0]), 32'b00101);
    chk("ovl_10101_count", 32'(match_count), 32'd2);

    // Non-overlapping: only the first "101" matches
    load_cfg(8'b101, 4'd3, 1'b0);
    chk("novl_count_kept", 32'(match_count), 32'd2);
    clear_count();
    send_stream(16'b10101, 5, yv);
    chk("novl_10101_y", 32'(yv[4:0]), 32'b00100);
    chk("novl_10101_count", 32'(match_count), 32'd1);

    // Pattern 1101 len 4, stream 1101101: pulses after bits 4 and 7
    load_cfg(8'b1101, 4'd4, 1'b1);
    clear_count();
    send_stream(16'b1101101, 7, yv);
    chk("p1101_y", 32'(yv[6:0]), 32'b0001001);
    chk("p1101_count", 32'(match_count), 32'd2);

    // "101" with 3 idle cycles after each bit; x toggles while idle
    load_cfg(8'b101, 4'd3, 1'b1);
    clear_count();
    bits3 = 3'b101;
    trace = '0;
    for (int i = 2; i >= 0; i--) begin
      cycle(1'b1, bits3[i]);
      trace = {trace[14:0], y};
      for (int k = 0; k < 3; k++) begin
        cycle(1'b0, ~bits3[i]);
        trace = {trace[14:0], y};
      end
    end
    chk("gap_trace", 32'(trace[11:0]), 32'b0000_0000_1000);
    chk("gap_count", 32'(match_count), 32'd1);

    // A bit sent together with cfg_load is dropped
    cfg_pattern = 8'b101;
    cfg_len     = 4'd3;
    cfg_overlap = 1'b1;
    cfg_load    = 1'b1;
    cycle(1'b1, 1'b1);
    send_stream(16'b01, 2, yv);
    chk("drop_bit_y", 32'(yv[1:0]), 32'b00);
    chk("drop_bit_state", 32'(state_dbg), 32'(S_FILL));

    // len = 1, pattern 1: every 1 is a hit; counter saturates at 15
    load_cfg(8'b1111_1111, 4'd1, 1'b1);
    clear_count();
    trace = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1);
      trace[0] = trace[0] | ~y;
    end
    chk("len1_all_hit", 32'(trace[0]), 32'd0);
    chk("sat_count", 32'(match_count), 32'd15);
    chk("len1_state_hit", 32'(state_dbg), 32'(S_HIT));
    cycle(1'b1, 1'b0);
    chk("len1_zero_y", 32'(y), 32'd0);
    chk("len1_zero_count", 32'(match_count), 32'd15);

    // clr_count coincident with a match gives 0
    clr_count = 1'b1;
    cycle(1'b1, 1'b1);
    chk("clr_win_y", 32'(y), 32'd1);
    chk("clr_win_count", 32'(match_count), 32'd0);

    // cfg_len = 0 rejected; coincident valid bit still processed
    cfg_pattern = 8'b0;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    cfg_load    = 1'b1;
    cycle(1'b1, 1'b1);
    chk("len0_cfg_err", 32'(cfg_err), 32'd1);
    chk("len0_y", 32'(y), 32'd1);
    chk("len0_count", 32'(match_count), 32'd1);
    cycle(1'b0, 1'b0);
    chk("len0_cfg_err_drop", 32'(cfg_err), 32'd0);

    // cfg_len = 9 rejected; old len-1 pattern still active
    cfg_pattern = 8'b0;
    cfg_len     = 4'd9;
    cfg_overlap = 1'b0;
    cfg_load    = 1'b1;
    cycle(1'b0, 1'b0);
    chk("len9_cfg_err", 32'(cfg_err), 32'd1);
    cycle(1'b1, 1'b1);
    chk("len9_cfg_err_drop", 32'(cfg_err), 32'd0);
    chk("len9_y", 32'(y), 32'd1);
    chk("len9_count", 32'(match_count), 32'd2);

    // Reset after "10" of "101": partial history discarded
    load_cfg(8'b101, 4'd3, 1'b1);
    send_stream(16'b10, 2, yv);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_count", 32'(match_count), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(S_FILL));
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_stream(16'b1101, 4, yv);
    chk("midrst_stream_y", 32'(yv[3:0]), 32'b0001);
    chk("midrst_stream_count", 32'(match_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
